// File: rtl/multiport_rf_sb.sv
// Multi-port register file with per-register busy scoreboard and reset clear sweep.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module multiport_rf_sb #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int NUM_RP = 4,
   parameter int NUM_WP = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     rf_ready,
   input  logic [NUM_RP*$clog2(NREG)-1:0] rf_raddr,
   output logic [NUM_RP*XLEN-1:0]   rf_rdata,
   output logic [NUM_RP-1:0]        rf_rbusy,
   input  logic [NUM_WP-1:0]        rf_wen,
   input  logic [NUM_WP*$clog2(NREG)-1:0] rf_waddr,
   input  logic [NUM_WP*XLEN-1:0]   rf_wdata,
   input  logic [NUM_WP-1:0]        sb_set,
   input  logic [NUM_WP*$clog2(NREG)-1:0] sb_addr
);

   localparam int AW = $clog2(NREG);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state;
   logic [AW-1:0]    idx;
   logic [XLEN-1:0]  mem [NREG];
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_nxt;

   // Reservations are applied after clears so a set wins on the same register.
   always_comb begin
      busy_nxt = busy;
      for (int i = 0; i < NUM_WP; i++)
         if (rf_wen[i]) busy_nxt[rf_waddr[i*AW +: AW]] = 1'b0;
      for (int i = 0; i < NUM_WP; i++)
         if (sb_set[i]) busy_nxt[sb_addr[i*AW +: AW]] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= CLEAR;
         idx      <= '0;
         busy     <= '0;
         rf_ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               idx <= idx + 1'b1;
               if (idx == AW'(NREG-1)) begin
                  state    <= RUN;
                  rf_ready <= 1'b1;
               end
            end
            RUN: busy <= busy_nxt;
            default: state <= CLEAR;
         endcase
      end
   end

   // Array has no reset; the sweep zeroes it, higher lanes override lower.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[idx] <= '0;
         end else begin
            for (int i = 0; i < NUM_WP; i++)
               if (rf_wen[i] && rf_waddr[i*AW +: AW] != '0)
                  mem[rf_waddr[i*AW +: AW]] <= rf_wdata[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      logic            hit;
      logic            set_hit;
      rf_rdata = '0;
      rf_rbusy = '0;
      for (int p = 0; p < NUM_RP; p++) begin
         a       = rf_raddr[p*AW +: AW];
         d       = (a == '0) ? '0 : mem[a];
         b       = busy[a];
         hit     = 1'b0;
         set_hit = 1'b0;
`ifdef RF_BYPASS_EN
         for (int i = 0; i < NUM_WP; i++) begin
            if (rf_wen[i] && rf_waddr[i*AW +: AW] == a && a != '0) begin
               d   = rf_wdata[i*XLEN +: XLEN];
               hit = 1'b1;
            end
            if (sb_set[i] && sb_addr[i*AW +: AW] == a)
               set_hit = 1'b1;
         end
         if (hit && !set_hit) b = 1'b0;
`endif
         if (rf_ready) begin
            rf_rdata[p*XLEN +: XLEN] = d;
            rf_rbusy[p]              = b;
         end
      end
   end

endmodule

// File: tb/tb_multiport_rf_sb.sv
// Directed self-checking bench for multiport_rf_sb (default parameters).
// Bypass-dependent expectations follow RF_BYPASS_EN when defined.
module tb_multiport_rf_sb;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRP  = 4;
   localparam int NWP  = 2;
   localparam int AW   = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              rf_ready;
   logic [NRP*AW-1:0] rf_raddr;
   logic [NRP*XLEN-1:0] rf_rdata;
   logic [NRP-1:0]    rf_rbusy;
   logic [NWP-1:0]    rf_wen;
   logic [NWP*AW-1:0] rf_waddr;
   logic [NWP*XLEN-1:0] rf_wdata;
   logic [NWP-1:0]    sb_set;
   logic [NWP*AW-1:0] sb_addr;

   int checks   = 0;
   int failures = 0;
   int cnt;

   multiport_rf_sb #(
      .XLEN(XLEN), .NREG(NREG), .NUM_RP(NRP), .NUM_WP(NWP)
   ) dut (
      .clock(clock), .reset(reset), .rf_ready(rf_ready),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_rbusy(rf_rbusy),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .sb_set(sb_set), .sb_addr(sb_addr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ra(input int p, input int a);
      rf_raddr[p*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int lane, input int a, input logic [63:0] d);
      rf_wen[lane]             = 1'b1;
      rf_waddr[lane*AW +: AW]  = AW'(a);
      rf_wdata[lane*XLEN +: XLEN] = d;
   endtask

   task automatic sb(input int lane, input int a);
      sb_set[lane]            = 1'b1;
      sb_addr[lane*AW +: AW]  = AW'(a);
   endtask

   task automatic idle();
      rf_wen = '0;
      sb_set = '0;
   endtask

   function automatic logic [63:0] rd(input int p);
      return rf_rdata[p*XLEN +: XLEN];
   endfunction

   initial begin
      reset    = 1'b1;
      rf_raddr = '0;
      rf_wen   = '0;
      rf_waddr = '0;
      rf_wdata = '0;
      sb_set   = '0;
      sb_addr  = '0;
      tick();
      check("rst_ready", 64'(rf_ready), 64'd0);
      check("rst_rbusy", 64'(rf_rbusy), 64'd0);
      reset = 1'b0;
      cnt = 0;
      while (!rf_ready && cnt < 100) begin
         cnt++;
         tick();
      end
      check("sweep_len", 64'(cnt), 64'd32);

      for (int g = 0; g < NREG / NRP; g++) begin
         for (int p = 0; p < NRP; p++) set_ra(p, g*NRP + p);
         #1;
         for (int p = 0; p < NRP; p++)
            check($sformatf("clr_r%0d", g*NRP + p), rd(p), 64'd0);
      end

      wr(0, 5, 64'hDEAD_BEEF);
      set_ra(0, 5);
      tick();
      idle();
      #1;
      check("wr5", rd(0), 64'hDEAD_BEEF);

      wr(0, 0, 64'h1234);
      set_ra(0, 0);
      tick();
      idle();
      #1;
      check("wr0_drop", rd(0), 64'd0);

      wr(0, 7, 64'h11);
      wr(1, 7, 64'h22);
      set_ra(1, 7);
      tick();
      idle();
      #1;
      check("lane_prio", rd(1), 64'h22);

      sb(0, 9);
      set_ra(1, 9);
      tick();
      idle();
      #1;
      check("sb_set9", 64'(rf_rbusy[1]), 64'd1);
      wr(1, 9, 64'h99);
      sb(0, 9);
      tick();
      idle();
      #1;
      check("set_beats_clr", 64'(rf_rbusy[1]), 64'd1);
      check("wr9_data", rd(1), 64'h99);
      wr(0, 9, 64'h9A);
      tick();
      idle();
      #1;
      check("clr9", 64'(rf_rbusy[1]), 64'd0);

      sb(1, 0);
      set_ra(0, 0);
      tick();
      idle();
      #1;
      check("sb_r0", 64'(rf_rbusy[0]), 64'd0);

      sb(0, 3);
      set_ra(2, 3);
      tick();
      idle();
      #1;
      check("busy3", 64'(rf_rbusy[2]), 64'd1);
      wr(0, 3, 64'h55);
      #1;
`ifdef RF_BYPASS_EN
      check("byp_data", rd(2), 64'h55);
      check("byp_busy", 64'(rf_rbusy[2]), 64'd0);
`else
      check("nobyp_data", rd(2), 64'd0);
      check("nobyp_busy", 64'(rf_rbusy[2]), 64'd1);
`endif
      tick();
      idle();
      #1;
      check("wr3_data", rd(2), 64'h55);
      check("wr3_busy", 64'(rf_rbusy[2]), 64'd0);

      wr(0, 20, 64'hAA);
      sb(1, 21);
      set_ra(0, 20);
      set_ra(3, 21);
      tick();
      idle();
      #1;
      check("wr20", rd(0), 64'hAA);
      check("busy21", 64'(rf_rbusy[3]), 64'd1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("gate_data", rd(0), 64'd0);
      check("gate_busy", 64'(rf_rbusy[3]), 64'd0);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cnt = 0;
      while (!rf_ready && cnt < 100) begin
         cnt++;
         if (cnt == 25) begin
            wr(0, 20, 64'hBB);
            sb(1, 21);
         end
         tick();
      end
      idle();
      #1;
      check("resweep_len", 64'(cnt), 64'd32);
      check("r20_cleared", rd(0), 64'd0);
      check("r21_notbusy", 64'(rf_rbusy[3]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
